frame_sequencer: RTL and testbench

//  Per-frame scheduler for the game loop: owns the frame-rate divider and the inter-phase settle timer.
//  On every frame tick it sequences three clients (erase, physics update, draw) via start/done handshakes.

---
 rtl/frame_sequencer_if.sv | 30 +++
 rtl/frame_sequencer.sv | 171 +++++++++++++++++
 tb/tb_frame_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: frame control plus erase/update/draw start-done handshakes.
// master = sequencer side, slave = top level and client side.
interface frame_sequencer_if #(
   parameter int OVR_W = 8
);
   logic             enable;
   logic             frame_tick;
   logic             erase_start;
   logic             erase_done;
   logic             update_start;
   logic             update_done;
   logic             draw_start;
   logic             draw_done;
   logic             busy;
   logic [2:0]       phase;
   logic [OVR_W-1:0] overrun_cnt;
   logic             timeout;

   modport master (
      input  enable, erase_done, update_done, draw_done,
      output frame_tick, erase_start, update_start, draw_start,
      output busy, phase, overrun_cnt, timeout
   );

   modport slave (
      output enable, erase_done, update_done, draw_done,
      input  frame_tick, erase_start, update_start, draw_start,
      input  busy, phase, overrun_cnt, timeout
   );
endinterface

// File: rtl/frame_sequencer.sv
// frame_sequencer: frame divider, erase/update/draw sequencing, settle gaps, overrun count.
// Define FRAME_SEQ_WDOG_EN to add the per-phase watchdog that drives timeout.
module frame_sequencer #(
   parameter int CLK_HZ        = 50_000_000,
   parameter int FRAME_HZ      = 120,
   parameter int SETTLE_CYCLES = 20,
   parameter int WDOG_CYCLES   = 1_000_000,
   parameter int OVR_W         = 8
) (
   input  logic               clk,
   input  logic               reset,
   frame_sequencer_if.master  bus
);
   localparam int FRAME_DIV = CLK_HZ / FRAME_HZ;
   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES);
   localparam logic [OVR_W-1:0] OVR_MAX  = '1;

   if (FRAME_DIV < 1 || WDOG_CYCLES < 2) begin : g_bad_cfg
      $error("frame_sequencer: bad timing parameters");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ERASE  = 3'd1,
      S_GAP_EU = 3'd2,
      S_UPDATE = 3'd3,
      S_GAP_UD = 3'd4,
      S_DRAW   = 3'd5
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [DIV_W-1:0] div_q;
   logic             tick_q;
   logic [SET_W-1:0] settle_q;
   logic [OVR_W-1:0] ovr_q;
   logic             es_q;
   logic             us_q;
   logic             ds_q;
   logic             done_ok;
   logic             in_gap;

   assign in_gap = (state_q == S_GAP_EU) || (state_q == S_GAP_UD);

`ifdef FRAME_SEQ_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES);
   localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYCLES - 1);

   logic [WD_W-1:0] wdog_q;
   logic            timeout_q;
   logic            wdog_exp;
   logic            in_phase;

   assign in_phase = (state_q == S_ERASE) || (state_q == S_UPDATE) ||
                     (state_q == S_DRAW);
`endif

   // Free-running frame divider with a registered wrap pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (bus.enable) begin
            if (div_q == DIV_LAST) begin
               div_q  <= '0;
               tick_q <= 1'b1;
            end else begin
               div_q <= div_q + DIV_W'(1);
            end
         end
      end
   end

   // Next phase: dones count only after the start cycle of their own phase.
   always_comb begin
      state_d = state_q;
      done_ok = 1'b0;
`ifdef FRAME_SEQ_WDOG_EN
      wdog_exp = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (tick_q) state_d = S_ERASE;
         end
         S_ERASE: begin
            done_ok = bus.erase_done && !es_q;
            if (done_ok) state_d = S_GAP_EU;
         end
         S_GAP_EU: begin
            if (settle_q == SET_LAST) state_d = S_UPDATE;
         end
         S_UPDATE: begin
            done_ok = bus.update_done && !us_q;
            if (done_ok) state_d = S_GAP_UD;
         end
         S_GAP_UD: begin
            if (settle_q == SET_LAST) state_d = S_DRAW;
         end
         S_DRAW: begin
            done_ok = bus.draw_done && !ds_q;
            if (done_ok) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef FRAME_SEQ_WDOG_EN
      if (in_phase && !done_ok && wdog_q == WDOG_LAST) begin
         wdog_exp = 1'b1;
         state_d  = S_IDLE;
      end
`endif
   end

   // State, phase-entry start pulses, settle gap timer and overrun count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         es_q     <= 1'b0;
         us_q     <= 1'b0;
         ds_q     <= 1'b0;
         settle_q <= '0;
         ovr_q    <= '0;
      end else begin
         state_q <= state_d;
         es_q    <= (state_d == S_ERASE) && (state_q != S_ERASE);
         us_q    <= (state_d == S_UPDATE) && (state_q != S_UPDATE);
         ds_q    <= (state_d == S_DRAW) && (state_q != S_DRAW);
         if (in_gap && state_d == state_q) begin
            settle_q <= settle_q + SET_W'(1);
         end else begin
            settle_q <= '0;
         end
         if (tick_q && state_q != S_IDLE && ovr_q != OVR_MAX) begin
            ovr_q <= ovr_q + OVR_W'(1);
         end
      end
   end

`ifdef FRAME_SEQ_WDOG_EN
   // Per-phase age counter; expiry drops back to idle with a one-cycle flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= wdog_exp;
         if (in_phase && state_d == state_q) begin
            wdog_q <= wdog_q + WD_W'(1);
         end else begin
            wdog_q <= '0;
         end
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.frame_tick   = tick_q;
   assign bus.erase_start  = es_q;
   assign bus.update_start = us_q;
   assign bus.draw_start   = ds_q;
   assign bus.phase        = state_q;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.overrun_cnt  = ovr_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: random and directed stimulus against a timestamp-style model.
// Honors FRAME_SEQ_WDOG_EN to pick the watchdog or the hang/overrun scenario.
module tb_frame_sequencer;
   localparam int DIV     = 100;
   localparam int SET     = 3;
   localparam int WD      = 50;
   localparam int OW      = 2;
   localparam int OVR_SAT = (1 << OW) - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   frame_sequencer_if #(.OVR_W(OW)) bus ();

   frame_sequencer #(
      .CLK_HZ(1000), .FRAME_HZ(10), .SETTLE_CYCLES(SET),
      .WDOG_CYCLES(WD), .OVR_W(OW)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // model: current phase number, first-cycle flag, cycles left in gap, age
   int m_div = 0, m_ph = 0, m_gap = 0, m_age = 0, m_ovr = 0;
   bit m_tick = 0, m_first = 0, m_to = 0;

   // client responder
   bit auto_ack = 0, spurious = 0, hold_draw = 0, hold_update = 0;
   int fixed_lat = 5;
   int e_cnt = 0, u_cnt = 0, d_cnt = 0;
   int rel1 = -1, rel2 = -1, rel_u = -1;

   // event log
   int t_tick = -1, t_es = -1, t_ed = -1, t_us = -1, t_ud = -1;
   int t_ds = -1, t_dd = -1, t_idle = -1;
   int n_ds = 0, n_to = 0;
   bit prev_busy = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_edge(bit r, bit en, bit ed, bit ud, bit dd);
      int  np;
      bit  ok;
      bit  nt;
      bit  nto;
      if (r) begin
         m_div = 0; m_ph = 0; m_gap = 0; m_age = 0; m_ovr = 0;
         m_tick = 0; m_first = 0; m_to = 0;
         return;
      end
      nt = 0;
      if (en) begin
         if (m_div == DIV - 1) begin
            m_div = 0;
            nt = 1;
         end else begin
            m_div++;
         end
      end
      if (m_tick && m_ph != 0 && m_ovr < OVR_SAT) m_ovr++;
      np = m_ph;
      ok = 0;
      case (m_ph)
         0: if (m_tick) np = 1;
         1: begin ok = ed && !m_first; if (ok) np = 2; end
         2: if (m_gap == 1) np = 3;
         3: begin ok = ud && !m_first; if (ok) np = 4; end
         4: if (m_gap == 1) np = 5;
         5: begin ok = dd && !m_first; if (ok) np = 0; end
         default: np = 0;
      endcase
      nto = 0;
`ifdef FRAME_SEQ_WDOG_EN
      if (m_ph inside {1, 3, 5} && !ok && m_age == WD - 1) begin
         np = 0;
         nto = 1;
      end
`endif
      m_first = (np != m_ph) && (np inside {1, 3, 5});
      if (np != m_ph) begin
         m_gap = SET + 1;
         m_age = 0;
      end else begin
         m_gap--;
         m_age++;
      end
      m_ph = np;
      m_tick = nt;
      m_to = nto;
   endtask

   function automatic int pick();
      return (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 12));
   endfunction

   task automatic respond();
      bus.erase_done = 0;
      bus.update_done = 0;
      bus.draw_done = 0;
      if (!auto_ack) return;
      if (bus.erase_start) e_cnt = pick();
      else if (e_cnt > 0) begin
         e_cnt--;
         if (e_cnt == 0) begin bus.erase_done = 1; t_ed = cyc; end
      end
      if (hold_update) begin
         if (cyc == rel_u) begin bus.update_done = 1; t_ud = cyc; end
      end else if (bus.update_start) u_cnt = pick();
      else if (u_cnt > 0) begin
         u_cnt--;
         if (u_cnt == 0) begin bus.update_done = 1; t_ud = cyc; end
      end
      if (hold_draw) begin
         if (cyc == rel1 || cyc == rel2) begin bus.draw_done = 1; t_dd = cyc; end
      end else if (bus.draw_start) d_cnt = pick();
      else if (d_cnt > 0) begin
         d_cnt--;
         if (d_cnt == 0) begin bus.draw_done = 1; t_dd = cyc; end
      end
      if (spurious && $urandom_range(0, 7) == 0) begin
         case ($urandom_range(0, 2))
            0: bus.erase_done = 1;
            1: bus.update_done = 1;
            default: bus.draw_done = 1;
         endcase
      end
   endtask

   task automatic step();
      bit r, e, a, b, c;
      r = reset; e = bus.enable;
      a = bus.erase_done; b = bus.update_done; c = bus.draw_done;
      @(posedge clk);
      model_edge(r, e, a, b, c);
      #1;
      cyc++;
      check("frame_tick", bus.frame_tick, m_tick);
      check("erase_start", bus.erase_start, m_first && m_ph == 1);
      check("update_start", bus.update_start, m_first && m_ph == 3);
      check("draw_start", bus.draw_start, m_first && m_ph == 5);
      check("phase", bus.phase, m_ph);
      check("busy", bus.busy, m_ph != 0);
      check("overrun_cnt", bus.overrun_cnt, m_ovr);
      check("timeout", bus.timeout, m_to);
      if (bus.frame_tick) t_tick = cyc;
      if (bus.erase_start) t_es = cyc;
      if (bus.update_start) t_us = cyc;
      if (bus.draw_start) begin t_ds = cyc; n_ds++; end
      if (bus.timeout) n_to++;
      if (prev_busy && !bus.busy) t_idle = cyc;
      prev_busy = bus.busy;
      respond();
   endtask

   task automatic do_reset(int n);
      reset = 1;
      e_cnt = 0; u_cnt = 0; d_cnt = 0;
      repeat (n) step();
      reset = 0;
      cyc = 0;
   endtask

   initial begin
      #1_000_000;
      fails++;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      bus.enable = 0;
      bus.erase_done = 0;
      bus.update_done = 0;
      bus.draw_done = 0;

      do_reset(3);
      check("rst_phase", bus.phase, 0);
      check("rst_ovr", bus.overrun_cnt, 0);
      check("rst_tick", bus.frame_tick, 0);

      // one frame with fixed 5-cycle client latency
      bus.enable = 1;
      auto_ack = 1;
      fixed_lat = 5;
      repeat (150) step();
      check("lit_tick", t_tick, 100);
      check("lit_es", t_es, 101);
      check("lit_ed", t_ed, 106);
      check("lit_us", t_us, 111);
      check("lit_ud", t_ud, 116);
      check("lit_ds", t_ds, 121);
      check("lit_dd", t_dd, 126);
      check("lit_idle", t_idle, 127);

      // random latencies, stray dones, enable toggling
      fixed_lat = 0;
      spurious = 1;
      repeat (900) begin
         if ($urandom_range(0, 49) == 0) bus.enable = !bus.enable;
         step();
      end
      bus.enable = 1;
      spurious = 0;
      fixed_lat = 5;

      // reset while in UPDATE
      for (int i = 0; i < 400 && bus.phase != 3; i++) step();
      check("reach_update", bus.phase, 3);
      do_reset(1);
      check("rst_mid_phase", bus.phase, 0);
      check("rst_mid_starts",
            {bus.erase_start, bus.update_start, bus.draw_start}, 0);
      check("rst_mid_ovr", bus.overrun_cnt, 0);

`ifdef FRAME_SEQ_WDOG_EN
      // missing update_done times out; second frame's done lands on expiry
      hold_update = 1;
      rel_u = 260;
      n_ds = 0;
      n_to = 0;
      while (cyc < 300) begin
         step();
         if (cyc == 161) begin
            check("wd_timeout", bus.timeout, 1);
            check("wd_idle", bus.phase, 0);
         end
         if (cyc == 162) check("wd_pulse_len", bus.timeout, 0);
         if (cyc == 199) check("wd_no_draw", n_ds, 0);
         if (cyc == 265) check("wd_done_wins", bus.draw_start, 1);
      end
      check("wd_count", n_to, 1);
      check("wd_ovr", bus.overrun_cnt, 0);
      hold_update = 0;
`else
      // draw_done withheld: overruns accumulate and saturate
      hold_draw = 1;
      rel1 = 400;
      rel2 = 750;
      while (cyc < 800) begin
         step();
         if (cyc == 201) check("ovr_1", bus.overrun_cnt, 1);
         if (cyc == 301) check("ovr_2", bus.overrun_cnt, 2);
         if (cyc == 401) begin
            check("ovr_coincide", bus.overrun_cnt, 3);
            check("coincide_idle", bus.phase, 0);
            check("no_restart", bus.erase_start, 0);
         end
         if (cyc == 650) check("hang_draw", bus.phase, 5);
         if (cyc == 701) check("ovr_sat", bus.overrun_cnt, OVR_SAT);
      end
      hold_draw = 0;
`endif

      // done on the start cycle and from the wrong client are ignored
      do_reset(1);
      auto_ack = 0;
      for (int i = 0; i < 150 && !bus.erase_start; i++) step();
      check("ign_reach", bus.erase_start, 1);
      bus.erase_done = 1;
      step();
      bus.update_done = 1;
      step();
      step();
      check("ign_phase", bus.phase, 1);
      bus.erase_done = 1;
      auto_ack = 1;
      step();
      check("ign_advance", bus.phase, 2);
      repeat (60) step();
      check("ign_done_idle", bus.phase, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
